// File: rtl/adq_pkg.sv
// Shared types and defaults for the multi-channel ADC acquisition sequencer.
package adq_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SELECT  = 3'd1,
      START   = 3'd2,
      CONVERT = 3'd3,
      STORE   = 3'd4,
      NEXT    = 3'd5,
      DONE    = 3'd6,
      ERROR   = 3'd7
   } state_t;

   localparam int DEF_N_CH        = 4;
   localparam int DEF_DATA_W      = 12;
   localparam int DEF_N_SAMPLES   = 16;
   localparam int DEF_TIMEOUT_CYC = 255;

   // Index width that never collapses to zero bits for a single-entry range.
   function automatic int clog2_min1(input int v);
      return (v > 1) ? $clog2(v) : 1;
   endfunction

endpackage

// File: rtl/adq_timeout_timer.sv
// Conversion watchdog: counts enabled cycles and flags the last permitted one.
module adq_timeout_timer
   import adq_pkg::*;
#(
   parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expired
);

   localparam int TW = clog2_min1(TIMEOUT_CYC);
   localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYC - 1);

   logic [TW-1:0] r_cnt;
   logic          w_expired;

   assign w_expired = (r_cnt == LAST);
   assign o_expired = w_expired;

   // Saturates at LAST so a stalled enable can never wrap back to zero.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt <= '0;
      end else if (i_clear) begin
         r_cnt <= '0;
      end else if (i_enable && !w_expired) begin
         r_cnt <= r_cnt + TW'(1);
      end
   end

endmodule

// File: rtl/adq_seq.sv
// Round-robin ADC acquisition sequencer: select, convert, store for N_CH x N_SAMPLES.
module adq_seq
   import adq_pkg::*;
#(
   parameter int N_CH        = DEF_N_CH,
   parameter int DATA_W      = DEF_DATA_W,
   parameter int N_SAMPLES   = DEF_N_SAMPLES,
   parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
   localparam int CH_W       = clog2_min1(N_CH),
   localparam int SMP_W      = $clog2(N_SAMPLES + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              init,
   input  logic              abort,
   input  logic              eoc,
   input  logic [DATA_W-1:0] adc_data,
   output logic              soc,
   output logic [CH_W-1:0]   ch_sel,
   output logic              wr_en,
   output logic [DATA_W-1:0] wr_data,
   output logic [CH_W-1:0]   wr_ch,
   input  logic              wr_ready,
   output logic              busy,
   output logic              done,
   output logic              timeout_err,
   output logic [SMP_W-1:0]  round_cnt,
   output logic [2:0]        state
);

   state_t            r_state, w_next;
   logic [CH_W-1:0]   r_ch_sel, r_wr_ch;
   logic [SMP_W-1:0]  r_round;
   logic [DATA_W-1:0] r_wr_data;
   logic              w_busy, w_expired, w_last_ch, w_last_round, w_start;

   assign w_busy       = !(r_state inside {IDLE, DONE, ERROR});
   assign w_last_ch    = (r_ch_sel == CH_W'(N_CH - 1));
   assign w_last_round = ((r_round + SMP_W'(1)) == SMP_W'(N_SAMPLES));
   assign w_start      = !w_busy && init;

   adq_timeout_timer #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_timer (
      .clk       (clk),
      .rst       (rst),
      .i_clear   (r_state == START),
      .i_enable  ((r_state == CONVERT) && !eoc),
      .o_expired (w_expired)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE, DONE, ERROR: if (init) w_next = SELECT;
         SELECT:            w_next = START;
         START:             w_next = CONVERT;
         CONVERT: begin
            // A conversion finishing on the final allowed cycle still counts.
            if (eoc)            w_next = STORE;
            else if (w_expired) w_next = ERROR;
         end
         STORE:             if (wr_ready) w_next = NEXT;
         NEXT:              w_next = (w_last_ch && w_last_round) ? DONE : SELECT;
         default:           w_next = IDLE;
      endcase
      if (abort && w_busy) w_next = IDLE;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ch_sel  <= '0;
         r_round   <= '0;
         r_wr_data <= '0;
         r_wr_ch   <= '0;
      end else if (w_start) begin
         r_ch_sel <= '0;
         r_round  <= '0;
      end else if (!abort) begin
         if ((r_state == CONVERT) && eoc) begin
            r_wr_data <= adc_data;
            r_wr_ch   <= r_ch_sel;
         end
         if (r_state == NEXT) begin
            if (w_last_ch) begin
               r_ch_sel <= '0;
               r_round  <= r_round + SMP_W'(1);
            end else begin
               r_ch_sel <= r_ch_sel + CH_W'(1);
            end
         end
      end
   end

   // Abort masks the strobes in its own cycle so no half-finished handshake escapes.
   assign soc         = (r_state == START) && !abort;
   assign wr_en       = (r_state == STORE) && !abort;
   assign busy        = w_busy;
   assign done        = (r_state == DONE);
   assign timeout_err = (r_state == ERROR);
   assign ch_sel      = r_ch_sel;
   assign wr_data     = r_wr_data;
   assign wr_ch       = r_wr_ch;
   assign round_cnt   = r_round;
   assign state       = r_state;

endmodule

// File: tb/tb_adq_seq.sv
// Self-checking bench for adq_seq with an ADC responder, write monitor and queue-based model.
module tb_adq_seq;

   localparam int N_CH = 2;
   localparam int DW   = 12;
   localparam int NS   = 3;
   localparam int TO   = 8;

   logic          clk, rst, init, abort, eoc, wr_ready;
   logic [DW-1:0] adc_data;
   logic          soc, wr_en, busy, done, timeout_err;
   logic [0:0]    ch_sel, wr_ch;
   logic [DW-1:0] wr_data;
   logic [1:0]    round_cnt;
   logic [2:0]    state;

   int pass_cnt = 0;
   int chk_cnt  = 0;
   int wr_cnt   = 0;
   int soc_cnt  = 0;

   logic [DW:0]   act_q[$];
   logic [DW-1:0] exp_q[$];

   bit adc_en     = 0;
   bit adc_rnd    = 0;
   bit adc_seq    = 1;
   bit stray_mode = 0;
   int adc_fixed  = 3;
   int skip_ch    = -1;
   int exp_base   = 0;

   adq_seq #(
      .N_CH(N_CH), .DATA_W(DW), .N_SAMPLES(NS), .TIMEOUT_CYC(TO)
   ) dut (
      .clk(clk), .rst(rst), .init(init), .abort(abort), .eoc(eoc),
      .adc_data(adc_data), .soc(soc), .ch_sel(ch_sel), .wr_en(wr_en),
      .wr_data(wr_data), .wr_ch(wr_ch), .wr_ready(wr_ready), .busy(busy),
      .done(done), .timeout_err(timeout_err), .round_cnt(round_cnt), .state(state)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got no finish, want finish before time limit");
      $fatal(1, "simulation time limit reached");
   end

   // Write/soc monitor, sampled mid-cycle.
   initial begin
      forever begin
         @(negedge clk);
         if (soc === 1'b1) soc_cnt++;
         if (wr_en === 1'b1 && wr_ready === 1'b1) begin
            wr_cnt++;
            act_q.push_back({wr_ch, wr_data});
         end
      end
   end

   // ADC model: answers each soc with one eoc pulse after a delay.
   initial begin
      int d;
      logic [DW-1:0] v;
      eoc = 0;
      adc_data = '0;
      forever begin
         @(negedge clk);
         if (adc_en && soc === 1'b1 && (skip_ch < 0 || int'(ch_sel) != skip_ch)) begin
            d = adc_rnd ? int'($urandom_range(1, 6)) : adc_fixed;
            v = adc_seq ? (12'h100 + 12'(exp_q.size() - exp_base)) : 12'($urandom);
            repeat (d) @(posedge clk);
            #1;
            eoc = 1;
            adc_data = v;
            exp_q.push_back(v);
            @(posedge clk);
            #1;
            eoc = 0;
         end else begin
            eoc = stray_mode ? ~eoc : 1'b0;
            if (stray_mode) adc_data = 12'($urandom);
         end
      end
   end

   task automatic wait_state(input logic [2:0] s, input int budget, output bit ok);
      ok = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (state === s) begin
            ok = 1;
            break;
         end
      end
   endtask

   task automatic pulse_init();
      @(posedge clk); #1 init = 1;
      @(posedge clk); #1 init = 0;
   endtask

   task automatic go_idle();
      @(posedge clk); #1 abort = 1;
      @(posedge clk); #1 abort = 0;
   endtask

   task automatic test_reset();
      rst = 1; init = 0; abort = 0; wr_ready = 1;
      #3 rst = 0;
      #9;
      chk_cnt++;
      if (state !== 3'd0) $display("FAIL rst_state: got %0d want 0", state); else pass_cnt++;
      chk_cnt++;
      if ({soc, wr_en, busy, done, timeout_err} !== 5'b0)
         $display("FAIL rst_flags: got %b want 00000", {soc, wr_en, busy, done, timeout_err});
      else pass_cnt++;
      chk_cnt++;
      if ({ch_sel, wr_ch, round_cnt, wr_data} !== '0)
         $display("FAIL rst_regs: got %h want 0", {ch_sel, wr_ch, round_cnt, wr_data});
      else pass_cnt++;
      @(posedge clk); #1 rst = 1;
      repeat (3) @(negedge clk);
      chk_cnt++;
      if (state !== 3'd0 || busy !== 1'b0) $display("FAIL rst_hold_idle: got state %0d busy %b want 0 0", state, busy);
      else pass_cnt++;
   endtask

   task automatic test_latency();
      adc_en = 0;
      go_idle();
      @(posedge clk); #1 init = 1;
      @(posedge clk); #1 init = 0;   // edge k
      @(negedge clk);                // cycle k+1
      chk_cnt++;
      if (state !== 3'd1 || ch_sel !== 1'b0 || soc !== 1'b0)
         $display("FAIL lat_k1: got state %0d ch %0d soc %b want 1 0 0", state, ch_sel, soc);
      else pass_cnt++;
      @(negedge clk);                // cycle k+2
      chk_cnt++;
      if (soc !== 1'b1 || ch_sel !== 1'b0) $display("FAIL lat_soc: got soc %b ch %0d want 1 0", soc, ch_sel);
      else pass_cnt++;
      @(negedge clk);                // cycle k+3
      chk_cnt++;
      if (soc !== 1'b0 || state !== 3'd3) $display("FAIL lat_soc_width: got soc %b state %0d want 0 3", soc, state);
      else pass_cnt++;
      go_idle();
   endtask

   task automatic test_scan(input bit rnd);
      int wb, sb, ab, eb, i;
      logic [DW:0] a;
      logic [DW-1:0] ed;
      wr_ready = 1; adc_en = 1; adc_rnd = rnd; adc_seq = !rnd; adc_fixed = 3; skip_ch = -1;
      eb = exp_q.size(); exp_base = eb;
      ab = act_q.size(); wb = wr_cnt; sb = soc_cnt;
      pulse_init();
      for (i = 0; i < 3000; i++) begin
         @(posedge clk); #1;
         if (done === 1'b1) break;
         wr_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      wr_ready = 1;
      chk_cnt++;
      if (done !== 1'b1) $display("FAIL scan_done_timeout: got done %b want 1", done); else pass_cnt++;
      @(negedge clk);
      chk_cnt++;
      if (wr_cnt - wb !== N_CH * NS) $display("FAIL scan_writes: got %0d want %0d", wr_cnt - wb, N_CH * NS);
      else pass_cnt++;
      chk_cnt++;
      if (soc_cnt - sb !== N_CH * NS) $display("FAIL scan_socs: got %0d want %0d", soc_cnt - sb, N_CH * NS);
      else pass_cnt++;
      chk_cnt++;
      if (round_cnt !== 2'(NS) || state !== 3'd6 || busy !== 1'b0)
         $display("FAIL scan_end: got round %0d state %0d busy %b want %0d 6 0", round_cnt, state, busy, NS);
      else pass_cnt++;
      for (int n = 0; n < N_CH * NS; n++) begin
         a = (act_q.size() > ab + n) ? act_q[ab + n] : 'x;
         if (rnd) ed = (exp_q.size() > eb + n) ? exp_q[eb + n] : 'x;
         else     ed = 12'h100 + 12'(n);
         chk_cnt++;
         if (a !== {1'(n % N_CH), ed})
            $display("FAIL scan_wr%0d: got ch %0d data %h want ch %0d data %h", n, a[DW], a[DW-1:0], n % N_CH, ed);
         else pass_cnt++;
      end
   endtask

   task automatic test_timeout();
      int wb, cnt;
      bit seen;
      adc_en = 1; adc_rnd = 0; adc_seq = 1; adc_fixed = 3; skip_ch = 1; wr_ready = 1;
      wb = wr_cnt;
      pulse_init();
      chk_cnt++;
      if (done !== 1'b0 || state !== 3'd1) $display("FAIL to_restart_from_done: got done %b state %0d want 0 1", done, state);
      else pass_cnt++;
      seen = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (soc === 1'b1 && ch_sel === 1'b1) begin seen = 1; break; end
      end
      cnt = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (state === 3'd3) cnt++; else break;
      end
      chk_cnt++;
      if (!seen || cnt !== TO) $display("FAIL to_convert_cycles: got %0d (soc seen %0d) want %0d", cnt, seen, TO);
      else pass_cnt++;
      chk_cnt++;
      if (state !== 3'd7 || timeout_err !== 1'b1 || ch_sel !== 1'b1 || wr_en !== 1'b0 || busy !== 1'b0)
         $display("FAIL to_error: got state %0d err %b ch %0d wr_en %b busy %b want 7 1 1 0 0",
                  state, timeout_err, ch_sel, wr_en, busy);
      else pass_cnt++;
      chk_cnt++;
      if (wr_cnt - wb !== 1) $display("FAIL to_writes: got %0d want 1", wr_cnt - wb); else pass_cnt++;
      go_idle();
      chk_cnt++;
      if (state !== 3'd7 || timeout_err !== 1'b1) $display("FAIL to_abort_ignored: got state %0d want 7", state);
      else pass_cnt++;
      skip_ch = -1;
      pulse_init();
      @(negedge clk);
      chk_cnt++;
      if (state !== 3'd1 || ch_sel !== 1'b0 || round_cnt !== 2'd0 || timeout_err !== 1'b0)
         $display("FAIL to_reinit: got state %0d ch %0d round %0d err %b want 1 0 0 0", state, ch_sel, round_cnt, timeout_err);
      else pass_cnt++;
      go_idle();
   endtask

   task automatic test_backpressure();
      int wb;
      bit ok;
      logic [DW-1:0] d0;
      logic [0:0] c0;
      go_idle();
      adc_en = 1; adc_rnd = 0; adc_seq = 0; adc_fixed = 3; skip_ch = -1; wr_ready = 0;
      pulse_init();
      wait_state(3'd4, 50, ok);
      chk_cnt++;
      if (!ok) $display("FAIL bp_reach_store: got state %0d want 4", state); else pass_cnt++;
      d0 = wr_data; c0 = wr_ch; wb = wr_cnt;
      chk_cnt++;
      if (d0 !== exp_q[$] || c0 !== 1'b0) $display("FAIL bp_capture: got %h ch %0d want %h ch 0", d0, c0, exp_q[$]);
      else pass_cnt++;
      for (int i = 0; i < 10; i++) begin
         if (i > 0) @(negedge clk);
         chk_cnt++;
         if (wr_en !== 1'b1 || wr_data !== d0 || wr_ch !== c0)
            $display("FAIL bp_hold%0d: got en %b data %h ch %0d want 1 %h %0d", i, wr_en, wr_data, wr_ch, d0, c0);
         else pass_cnt++;
      end
      chk_cnt++;
      if (wr_cnt !== wb) $display("FAIL bp_no_write: got %0d want %0d", wr_cnt - wb, 0); else pass_cnt++;
      @(posedge clk); #1 wr_ready = 1;
      @(negedge clk);
      chk_cnt++;
      if (wr_en !== 1'b1) $display("FAIL bp_release: got wr_en %b want 1", wr_en); else pass_cnt++;
      @(negedge clk);
      chk_cnt++;
      if (soc !== 1'b0 || wr_en !== 1'b0) $display("FAIL bp_w1: got soc %b wr_en %b want 0 0", soc, wr_en); else pass_cnt++;
      @(negedge clk);
      chk_cnt++;
      if (soc !== 1'b0) $display("FAIL bp_w2: got soc %b want 0", soc); else pass_cnt++;
      @(negedge clk);
      chk_cnt++;
      if (soc !== 1'b1 || ch_sel !== 1'b1) $display("FAIL bp_next_soc: got soc %b ch %0d want 1 1", soc, ch_sel);
      else pass_cnt++;
      @(negedge clk);
      chk_cnt++;
      if (wr_cnt - wb !== 1) $display("FAIL bp_one_write: got %0d want 1", wr_cnt - wb); else pass_cnt++;
      go_idle();
   endtask

   task automatic test_abort();
      int wb, sb;
      bit ok;
      go_idle();
      adc_en = 1; adc_rnd = 0; adc_fixed = 2; skip_ch = -1; wr_ready = 0;
      pulse_init();
      wait_state(3'd4, 50, ok);
      chk_cnt++;
      if (!ok) $display("FAIL ab_reach_store: got state %0d want 4", state); else pass_cnt++;
      wb = wr_cnt; sb = soc_cnt;
      @(posedge clk); #1 abort = 1;
      @(negedge clk);
      chk_cnt++;
      if (wr_en !== 1'b0) $display("FAIL ab_wr_drop: got wr_en %b want 0", wr_en); else pass_cnt++;
      @(posedge clk); #1 abort = 0;
      @(negedge clk);
      chk_cnt++;
      if (state !== 3'd0 || busy !== 1'b0 || wr_en !== 1'b0)
         $display("FAIL ab_idle: got state %0d busy %b wr_en %b want 0 0 0", state, busy, wr_en);
      else pass_cnt++;
      wr_ready = 1; stray_mode = 1;
      repeat (12) @(negedge clk);
      stray_mode = 0;
      @(negedge clk);
      chk_cnt++;
      if (state !== 3'd0 || wr_cnt !== wb || soc_cnt !== sb)
         $display("FAIL ab_stray_eoc: got state %0d writes %0d socs %0d want 0 0 0", state, wr_cnt - wb, soc_cnt - sb);
      else pass_cnt++;
   endtask

   task automatic test_async_reset();
      bit ok, seen;
      go_idle();
      adc_en = 1; adc_rnd = 0; adc_seq = 1; adc_fixed = 3; skip_ch = 1; wr_ready = 1;
      exp_base = exp_q.size();
      pulse_init();
      ok = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (state === 3'd3 && ch_sel === 1'b1) begin ok = 1; break; end
      end
      chk_cnt++;
      if (!ok) $display("FAIL ar_reach_convert: got state %0d ch %0d want 3 1", state, ch_sel); else pass_cnt++;
      #2 rst = 0;
      #1;
      chk_cnt++;
      if (state !== 3'd0 || {soc, wr_en, busy, done, timeout_err} !== 5'b0 ||
          {ch_sel, wr_ch, round_cnt, wr_data} !== '0)
         $display("FAIL ar_async_clear: got state %0d flags %b regs %h want 0 0 0",
                  state, {soc, wr_en, busy, done, timeout_err}, {ch_sel, wr_ch, round_cnt, wr_data});
      else pass_cnt++;
      skip_ch = -1;
      @(posedge clk); #1 rst = 1;
      pulse_init();
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (soc === 1'b1) begin seen = 1; break; end
      end
      chk_cnt++;
      if (!seen || ch_sel !== 1'b0) $display("FAIL ar_restart: got soc seen %0d ch %0d want 1 0", seen, ch_sel);
      else pass_cnt++;
      go_idle();
   endtask

   initial begin
      test_reset();
      test_latency();
      test_scan(1'b0);
      test_scan(1'b1);
      test_scan(1'b1);
      test_timeout();
      test_backpressure();
      test_abort();
      test_async_reset();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/adq_seq.md
Name: adq_seq

Overview:
Parametrised multi-channel ADC acquisition sequencer, successor to the single-channel acquisition FSM. On `init`, it scans `N_CH` analog channels round-robin for `N_SAMPLES` rounds. Per conversion it drives the channel mux, pulses start-of-conversion and waits for `eoc` with a timeout. It then pushes the captured sample to a downstream buffer through a ready/valid write port. Sits between the ADC front-end and the sample FIFO/RAM.

Parameters:
N_CH, 4, number of analog channels scanned (≥1)
DATA_W, 12, ADC sample width
N_SAMPLES, 16, scan rounds per acquisition (≥1)
TIMEOUT_CYC, 255, max cycles in CONVERT waiting for eoc before error (≥1)
CH_W, $clog2(N_CH) (min 1), derived channel index width
SMP_W, $clog2(N_SAMPLES+1), derived round counter width

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
init  in  1  start acquisition; sampled only in IDLE, DONE, ERROR
abort  in  1  cancel acquisition; returns to IDLE
eoc  in  1  ADC end-of-conversion
adc_data  in  DATA_W  ADC result, valid when eoc=1
soc  out  1  start-of-conversion, one-cycle pulse
ch_sel  out  CH_W  analog mux channel select
wr_en  out  1  write valid to sample buffer
wr_data  out  DATA_W  captured sample
wr_ch  out  CH_W  channel tag of wr_data
wr_ready  in  1  buffer accepts write when wr_en&wr_ready
busy  out  1  high in every state except IDLE, DONE, ERROR
done  out  1  high while in DONE
timeout_err  out  1  high while in ERROR
round_cnt  out  SMP_W  completed scan rounds
state  out  3  current state encoding (debug)

Behaviour:
- Reset (rst=0, async): state=IDLE. All outputs 0. Channel, round, timer and data registers 0.
- States: IDLE, SELECT, START, CONVERT, STORE, NEXT, DONE, ERROR.
- IDLE/DONE/ERROR + init=1 → SELECT. On entry, ch_sel=0 and round_cnt=0; done and timeout_err clear.
- SELECT: one cycle, mux settle; ch_sel stable → START.
- START: soc=1 for exactly this cycle; timer cleared → CONVERT. Latency: init high at edge k gives soc=1 in cycle k+2.
- CONVERT:
  - eoc=1 → adc_data latched into wr_data, wr_ch=ch_sel → STORE.
  - Otherwise the timer increments. When the timer equals TIMEOUT_CYC-1 with eoc=0 → ERROR, so CONVERT lasts at most TIMEOUT_CYC cycles.
  - eoc in the same cycle as the timeout: eoc wins.
- STORE: wr_en=1, wr_data/wr_ch held stable. Leave to NEXT on the cycle wr_en&wr_ready. No cap on backpressure; no sample dropped or duplicated.
- NEXT: one cycle.
  - If ch_sel<N_CH-1: ch_sel+1 → SELECT.
  - Else ch_sel=0, round_cnt+1. If the new round_cnt==N_SAMPLES → DONE, else → SELECT.
- DONE: done=1, round_cnt holds N_SAMPLES; wait for init.
- ERROR: timeout_err=1. ch_sel holds the failing channel; wait for init.
- abort=1 in any busy state → IDLE on the next edge. wr_en and soc drop immediately; no partial write is completed. abort has priority over all other transitions. abort in IDLE/DONE/ERROR is ignored.
- init while busy is ignored.
- eoc outside CONVERT is ignored.
- Reset mid-operation: immediate return to reset values, independent of clk.
- N_CH=1: ch_sel is constantly 0 and every NEXT advances the round.
- Total writes per completed acquisition = N_CH*N_SAMPLES.

Decomposition:
- Package adq_pkg: state typedef enum logic[2:0] with IDLE=0, SELECT=1, START=2, CONVERT=3, STORE=4, NEXT=5, DONE=6, ERROR=7. Also default parameter constants.
- One sub-module, adq_timeout_timer: clear/enable/expired, parameter TIMEOUT_CYC. It is instantiated once in CONVERT.

Test Plan:
- N_CH=2, N_SAMPLES=3, wr_ready=1, eoc 3 cycles after each soc, adc_data=0x100+n → 6 writes with wr_ch 0,1,0,1,0,1 and data 0x100..0x105. done=1 after the last NEXT, round_cnt=3, soc count=6.
- init at edge k from IDLE → soc=1 exactly in cycle k+2, one cycle wide. ch_sel=0 from cycle k+1.
- TIMEOUT_CYC=8, eoc never asserted on channel 1 → ERROR after 8 CONVERT cycles. timeout_err=1, ch_sel=1, wr_en stays 0. init then restarts from ch 0, round 0.
- wr_ready held 0 for 10 cycles in STORE → wr_en, wr_data and wr_ch stable for all 10 cycles. Exactly one write on release; the next soc follows 3 cycles later.
- abort asserted during STORE with wr_ready=0 → IDLE next edge, wr_en=0, busy=0, no write handshake. eoc pulses afterwards cause no activity.
- rst pulled low mid-CONVERT between clock edges → all outputs 0 immediately. After rst release and init, the sequence restarts at ch 0.
